voice_allocator: RTL

- Polyphonic voice scheduler between the MIDI parser and the oscillator/envelope bank.
- Accepts parsed note events and assigns each note-on to one of NUM_VOICES voices: free voice first, else steal the oldest.
- Releases matching voices on note-off.
- Drives per-voice note index, velocity, gate and retrigger strobes consumed by the synth voices.

---
 rtl/voice_allocator_if.sv | 31 +++
 rtl/voice_allocator.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/voice_allocator_if.sv
// Note-event handshake and per-voice synth control bundle between the MIDI
// parser (master) and the voice allocator (slave).
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4
);
    // Handshake: an event is taken only on a cycle where noteValid and noteReady
    // are both high; noteValid while noteReady is low is dropped and flagged.
    logic                      noteValid;
    logic                      notePlaying;
    logic [6:0]                noteIndex;
    logic [6:0]                noteVelocity;
    logic                      noteReady;
    logic                      droppedEvent;
    logic [7*NUM_VOICES-1:0]   voiceIndex;
    logic [7*NUM_VOICES-1:0]   voiceVelocity;
    logic [NUM_VOICES-1:0]     voiceGate;
    logic [NUM_VOICES-1:0]     voiceTrigger;
    logic [3:0]                activeCount;

    modport master (
        output noteValid, notePlaying, noteIndex, noteVelocity,
        input  noteReady, droppedEvent, voiceIndex, voiceVelocity,
        input  voiceGate, voiceTrigger, activeCount
    );

    modport slave (
        input  noteValid, notePlaying, noteIndex, noteVelocity,
        output noteReady, droppedEvent, voiceIndex, voiceVelocity,
        output voiceGate, voiceTrigger, activeCount
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans voices one per cycle, then retriggers a
// matching voice, allocates a free one, or steals the oldest.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    voice_allocator_if.slave   bus,
    output logic [1:0]         debugState
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VW-1:0]    LAST_VOICE = VW'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] OLDEST_AGE = AGE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, APPLY = 2'd2} state_t;
    state_t state, stateNext;

    logic [6:0]            idxReg [NUM_VOICES];
    logic [6:0]            velReg [NUM_VOICES];
    logic [AGE_W-1:0]      age    [NUM_VOICES];
    logic [NUM_VOICES-1:0] gateReg, trigReg, gateNext, releaseMask;
    logic [3:0]            countReg, countNext;
    logic                  droppedReg;

    logic                  latOn;
    logic [6:0]            latIndex, latVelocity;
    logic [VW-1:0]         scanIdx, matchVoice, freeVoice, oldestVoice, target;
    logic                  matchHit, freeHit;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.noteValid) stateNext = SCAN;
            SCAN:    if (scanIdx == LAST_VOICE) stateNext = APPLY;
            APPLY:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Retrigger beats free allocation, so two gated voices never share an index.
    always_comb begin
        target = oldestVoice;
        if (matchHit)     target = matchVoice;
        else if (freeHit) target = freeVoice;
    end

    always_comb begin
        gateNext  = gateReg;
        countNext = 4'd0;
        if (state == APPLY) begin
            if (latOn) gateNext[target] = 1'b1;
            else       gateNext         = gateReg & ~releaseMask;
        end
        for (int v = 0; v < NUM_VOICES; v++) countNext = countNext + 4'(gateNext[v]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gateReg     <= '0;
            trigReg     <= '0;
            countReg    <= 4'd0;
            droppedReg  <= 1'b0;
            latOn       <= 1'b0;
            latIndex    <= 7'd0;
            latVelocity <= 7'd0;
            scanIdx     <= '0;
            matchHit    <= 1'b0;
            freeHit     <= 1'b0;
            matchVoice  <= '0;
            freeVoice   <= '0;
            oldestVoice <= '0;
            releaseMask <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                idxReg[v] <= 7'd0;
                velReg[v] <= 7'd0;
                age[v]    <= AGE_W'(v);
            end
        end else begin
            droppedReg <= bus.noteValid && (state != IDLE);
            trigReg    <= '0;
            case (state)
                IDLE: if (bus.noteValid) begin
                    // Velocity-0 note-on is a note-off by MIDI convention.
                    latOn       <= bus.notePlaying && (bus.noteVelocity != 7'd0);
                    latIndex    <= bus.noteIndex;
                    latVelocity <= bus.noteVelocity;
                    scanIdx     <= '0;
                    matchHit    <= 1'b0;
                    freeHit     <= 1'b0;
                    matchVoice  <= '0;
                    freeVoice   <= '0;
                    oldestVoice <= '0;
                    releaseMask <= '0;
                end
                SCAN: begin
                    if (gateReg[scanIdx] && (idxReg[scanIdx] == latIndex)) begin
                        releaseMask[scanIdx] <= 1'b1;
                        if (!matchHit) begin
                            matchHit   <= 1'b1;
                            matchVoice <= scanIdx;
                        end
                    end
                    if (!gateReg[scanIdx] && !freeHit) begin
                        freeHit   <= 1'b1;
                        freeVoice <= scanIdx;
                    end
                    if (age[scanIdx] == OLDEST_AGE) oldestVoice <= scanIdx;
                    scanIdx <= scanIdx + 1'b1;
                end
                APPLY: begin
                    gateReg  <= gateNext;
                    countReg <= countNext;
                    if (latOn) begin
                        idxReg[target] <= latIndex;
                        velReg[target] <= latVelocity;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            trigReg[v] <= (target == VW'(v));
                            if (target == VW'(v))          age[v] <= '0;
                            else if (age[v] < age[target]) age[v] <= age[v] + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.voiceIndex    = '0;
        bus.voiceVelocity = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            bus.voiceIndex[7*v +: 7]    = idxReg[v];
            bus.voiceVelocity[7*v +: 7] = velReg[v];
        end
    end

    assign bus.noteReady    = (state == IDLE);
    assign bus.droppedEvent = droppedReg;
    assign bus.voiceGate    = gateReg;
    assign bus.voiceTrigger = trigReg;
    assign bus.activeCount  = countReg;
    assign debugState       = state;
endmodule
